id_exe_core: RTL and testbench

- Decode-through-execute slice of the 5-stage in-order 32-bit pipeline.
- Contains the ID stage (decoder, 32x32 register file), the internal ID/EXE pipeline register, the EXE stage (ALU, branch resolution) and the EXE/MEM output register.
- Fed by the IF/ID register. Drives the MEM stage. Receives the writeback port from WB.

---
 rtl/id_exe_core_if.sv | 40 ++++
 rtl/id_exe_core.sv | 254 +++++++++++++++++++++++++
 tb/tb_id_exe_core.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_exe_core_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : id_exe_core_if
// Description : Bundle between the surrounding pipeline and the ID/EXE
//               slice: the IF/ID instruction feed, the WB writeback port
//               and the EXE/MEM register outputs with the branch decision.
//   master : drives PC_in, Instruction and WB_*_in; observes the outputs.
//   slave  : the id_exe_core side.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_exe_core_if;
  logic [31:0] PC_in;
  logic [31:0] Instruction;
  logic        WB_EN_in;
  logic [4:0]  WB_Dest_in;
  logic [31:0] WB_Value_in;
  logic [31:0] PC;
  logic [31:0] ALU_result;
  logic [31:0] ST_val;
  logic [4:0]  Dest;
  logic        WB_EN;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic        Branch_taken;
  logic [31:0] BranchAddr;

  modport master (
    output PC_in, Instruction, WB_EN_in, WB_Dest_in, WB_Value_in,
    input  PC, ALU_result, ST_val, Dest, WB_EN, MEM_R_EN, MEM_W_EN,
           Branch_taken, BranchAddr
  );

  modport slave (
    input  PC_in, Instruction, WB_EN_in, WB_Dest_in, WB_Value_in,
    output PC, ALU_result, ST_val, Dest, WB_EN, MEM_R_EN, MEM_W_EN,
           Branch_taken, BranchAddr
  );
endinterface
`default_nettype wire

// File: rtl/id_exe_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : id_exe_core
// Description : Decode-through-execute slice of a 5-stage in-order 32-bit
//               pipeline: decoder, 32x32 register file with write bypass,
//               ID/EXE register, ALU and branch resolution, EXE/MEM register.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - id_exe_core_if.slave (IF/ID feed, WB port, EXE/MEM
//                      outputs, combinational Branch_taken / BranchAddr)
// Parameters  : RF_RESET_VALUE - value loaded into every RF entry on reset
// Options     : `define ID_EXE_FORWARD_EN enables EXE/MEM -> EXE forwarding
// Revision    : 1.0 - initial release
// ============================================================================
module id_exe_core #(
  parameter logic [31:0] RF_RESET_VALUE = 32'h0
) (
  input  wire logic     clk,
  input  wire logic     rst,
  id_exe_core_if.slave  bus
);

  localparam logic [5:0] c_OP_NOP  = 6'd0;
  localparam logic [5:0] c_OP_ADD  = 6'd1;
  localparam logic [5:0] c_OP_SUB  = 6'd3;
  localparam logic [5:0] c_OP_AND  = 6'd5;
  localparam logic [5:0] c_OP_OR   = 6'd6;
  localparam logic [5:0] c_OP_NOR  = 6'd7;
  localparam logic [5:0] c_OP_XOR  = 6'd8;
  localparam logic [5:0] c_OP_SLA  = 6'd9;
  localparam logic [5:0] c_OP_SLL  = 6'd10;
  localparam logic [5:0] c_OP_SRA  = 6'd11;
  localparam logic [5:0] c_OP_SRL  = 6'd12;
  localparam logic [5:0] c_OP_ADDI = 6'd32;
  localparam logic [5:0] c_OP_SUBI = 6'd33;
  localparam logic [5:0] c_OP_LD   = 6'd36;
  localparam logic [5:0] c_OP_ST   = 6'd37;
  localparam logic [5:0] c_OP_BEZ  = 6'd40;
  localparam logic [5:0] c_OP_BNE  = 6'd41;
  localparam logic [5:0] c_OP_JMP  = 6'd42;

  // --------------------------------------------------------------------------
  // ID stage
  // --------------------------------------------------------------------------
  logic [31:0] r_rf [0:31];

  logic [5:0]  w_op;
  logic [4:0]  w_dest;
  logic [4:0]  w_src1;
  logic [4:0]  w_src2;
  logic [31:0] w_imm;
  logic [5:0]  w_op_eff;
  logic        w_wb;
  logic        w_mr;
  logic        w_mw;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  assign w_op   = bus.Instruction[31:26];
  assign w_dest = bus.Instruction[25:21];
  assign w_src1 = bus.Instruction[20:16];
  assign w_imm  = {{16{bus.Instruction[15]}}, bus.Instruction[15:0]};
  // ST and BNE use the dest field as their second source register.
  assign w_src2 = ((w_op == c_OP_ST) || (w_op == c_OP_BNE)) ?
                  bus.Instruction[25:21] : bus.Instruction[15:11];

  // Unknown opcodes collapse to NOP so EXE only ever sees legal encodings.
  always_comb begin
    w_op_eff = c_OP_NOP;
    w_wb     = 1'b0;
    w_mr     = 1'b0;
    w_mw     = 1'b0;
    case (w_op)
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_NOR, c_OP_XOR,
      c_OP_SLA, c_OP_SLL, c_OP_SRA, c_OP_SRL, c_OP_ADDI, c_OP_SUBI: begin
        w_op_eff = w_op;
        w_wb     = 1'b1;
      end
      c_OP_LD: begin
        w_op_eff = w_op;
        w_wb     = 1'b1;
        w_mr     = 1'b1;
      end
      c_OP_ST: begin
        w_op_eff = w_op;
        w_mw     = 1'b1;
      end
      c_OP_BEZ, c_OP_BNE, c_OP_JMP: begin
        w_op_eff = w_op;
      end
      default: ;
    endcase
  end

  // Register reads with bypass of a writeback landing on the same edge.
  always_comb begin
    w_rd1 = r_rf[w_src1];
    w_rd2 = r_rf[w_src2];
    if (bus.WB_EN_in && (bus.WB_Dest_in == w_src1)) w_rd1 = bus.WB_Value_in;
    if (bus.WB_EN_in && (bus.WB_Dest_in == w_src2)) w_rd2 = bus.WB_Value_in;
    if (w_src1 == 5'd0) w_rd1 = 32'h0;
    if (w_src2 == 5'd0) w_rd2 = 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= RF_RESET_VALUE;
    end else if (bus.WB_EN_in && (bus.WB_Dest_in != 5'd0)) begin
      r_rf[bus.WB_Dest_in] <= bus.WB_Value_in;
    end
  end

  // --------------------------------------------------------------------------
  // ID/EXE register
  // --------------------------------------------------------------------------
  logic [31:0] r_ie_pc;
  logic [31:0] r_ie_a;
  logic [31:0] r_ie_b;
  logic [31:0] r_ie_imm;
  logic [4:0]  r_ie_dest;
  logic [5:0]  r_ie_op;
  logic        r_ie_wb;
  logic        r_ie_mr;
  logic        r_ie_mw;
  logic        w_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_taken) begin
      // A taken branch in EXE squashes the instruction currently in ID.
      r_ie_pc   <= 32'h0;
      r_ie_a    <= 32'h0;
      r_ie_b    <= 32'h0;
      r_ie_imm  <= 32'h0;
      r_ie_dest <= 5'd0;
      r_ie_op   <= c_OP_NOP;
      r_ie_wb   <= 1'b0;
      r_ie_mr   <= 1'b0;
      r_ie_mw   <= 1'b0;
    end else begin
      r_ie_pc   <= bus.PC_in;
      r_ie_a    <= w_rd1;
      r_ie_b    <= w_rd2;
      r_ie_imm  <= w_imm;
      r_ie_dest <= w_dest;
      r_ie_op   <= w_op_eff;
      r_ie_wb   <= w_wb;
      r_ie_mr   <= w_mr;
      r_ie_mw   <= w_mw;
    end
  end

  // --------------------------------------------------------------------------
  // EXE stage
  // --------------------------------------------------------------------------
  logic [31:0] r_em_pc;
  logic [31:0] r_em_alu;
  logic [31:0] r_em_st;
  logic [4:0]  r_em_dest;
  logic        r_em_wb;
  logic        r_em_mr;
  logic        r_em_mw;

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_alu;
  logic [31:0] w_baddr;

`ifdef ID_EXE_FORWARD_EN
  logic [4:0] r_ie_s1;
  logic [4:0] r_ie_s2;
  logic       w_fwd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_taken) begin
      r_ie_s1 <= 5'd0;
      r_ie_s2 <= 5'd0;
    end else begin
      r_ie_s1 <= w_src1;
      r_ie_s2 <= w_src2;
    end
  end

  // A load's ALU_result is an address, not data, so it is never forwarded.
  assign w_fwd_ok = r_em_wb && !r_em_mr;
  assign w_a = (w_fwd_ok && (r_ie_s1 != 5'd0) && (r_ie_s1 == r_em_dest)) ?
               r_em_alu : r_ie_a;
  assign w_b = (w_fwd_ok && (r_ie_s2 != 5'd0) && (r_ie_s2 == r_em_dest)) ?
               r_em_alu : r_ie_b;
`else
  assign w_a = r_ie_a;
  assign w_b = r_ie_b;
`endif

  always_comb begin
    w_alu   = 32'h0;
    w_taken = 1'b0;
    case (r_ie_op)
      c_OP_ADD:            w_alu = w_a + w_b;
      c_OP_SUB:            w_alu = w_a - w_b;
      c_OP_AND:            w_alu = w_a & w_b;
      c_OP_OR:             w_alu = w_a | w_b;
      c_OP_NOR:            w_alu = ~(w_a | w_b);
      c_OP_XOR:            w_alu = w_a ^ w_b;
      c_OP_SLA, c_OP_SLL:  w_alu = w_a << w_b[4:0];
      c_OP_SRA:            w_alu = 32'($signed(w_a) >>> w_b[4:0]);
      c_OP_SRL:            w_alu = w_a >> w_b[4:0];
      c_OP_ADDI, c_OP_LD,
      c_OP_ST:             w_alu = w_a + r_ie_imm;
      c_OP_SUBI:           w_alu = w_a - r_ie_imm;
      c_OP_BEZ:            w_taken = (w_a == 32'h0);
      c_OP_BNE:            w_taken = (w_a != w_b);
      c_OP_JMP:            w_taken = 1'b1;
      default: ;
    endcase
  end

  assign w_baddr = r_ie_pc + {r_ie_imm[29:0], 2'b00};

  // --------------------------------------------------------------------------
  // EXE/MEM register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_em_pc   <= 32'h0;
      r_em_alu  <= 32'h0;
      r_em_st   <= 32'h0;
      r_em_dest <= 5'd0;
      r_em_wb   <= 1'b0;
      r_em_mr   <= 1'b0;
      r_em_mw   <= 1'b0;
    end else begin
      r_em_pc   <= r_ie_pc;
      r_em_alu  <= w_alu;
      r_em_st   <= w_b;
      r_em_dest <= r_ie_dest;
      r_em_wb   <= r_ie_wb;
      r_em_mr   <= r_ie_mr;
      r_em_mw   <= r_ie_mw;
    end
  end

  assign bus.PC           = r_em_pc;
  assign bus.ALU_result   = r_em_alu;
  assign bus.ST_val       = r_em_st;
  assign bus.Dest         = r_em_dest;
  assign bus.WB_EN        = r_em_wb;
  assign bus.MEM_R_EN     = r_em_mr;
  assign bus.MEM_W_EN     = r_em_mw;
  assign bus.Branch_taken = w_taken;
  assign bus.BranchAddr   = w_baddr;

endmodule
`default_nettype wire

// File: tb/tb_id_exe_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_id_exe_core
// Description : Self-checking bench for id_exe_core: directed vector table,
//               hand-written multi-cycle sequences (bypass, squash,
//               dependent pair, mid-run reset) and randomized instructions
//               checked against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_exe_core;

  localparam logic [31:0] c_RST = 32'h1234_5678;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_exe_core_if bus ();

  id_exe_core #(.RF_RESET_VALUE(c_RST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] st;
    logic [4:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        tk;
    logic [31:0] ba;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_rf [32];
  vec_t        tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mkr(input int op, d, s1, s2);
    logic [31:0] r;
    r = {op[5:0], d[4:0], s1[4:0], s2[4:0], 11'd0};
    return r;
  endfunction

  function automatic logic [31:0] mki(input int op, d, s1, input logic [15:0] imm);
    logic [31:0] r;
    r = {op[5:0], d[4:0], s1[4:0], imm};
    return r;
  endfunction

  function automatic vec_t V(input logic [31:0] ins, pc, alu, st, input logic [4:0] dest,
                             input logic wb, mr, mw, tk, input logic [31:0] ba);
    vec_t v;
    v.ins = ins; v.pc = pc; v.alu = alu; v.st = st; v.dest = dest;
    v.wb = wb; v.mr = mr; v.mw = mw; v.tk = tk; v.ba = ba;
    return v;
  endfunction

  // Instruction-level reference: what the instruction means architecturally.
  function automatic vec_t model(input logic [31:0] ins, input logic [31:0] pc);
    vec_t        r;
    int          op  = int'(ins[31:26]);
    logic [4:0]  d   = ins[25:21];
    logic [31:0] a   = m_rf[ins[20:16]];
    logic [31:0] b   = m_rf[(op == 37 || op == 41) ? d : ins[15:11]];
    logic [31:0] imm = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] sa  = {27'd0, b[4:0]};
    r = V(ins, pc, 32'h0, b, d, 1'b0, 1'b0, 1'b0, 1'b0, pc + imm * 4);
    case (op)
      1:  begin r.alu = a + b;                r.wb = 1'b1; end
      3:  begin r.alu = a - b;                r.wb = 1'b1; end
      5:  begin r.alu = a & b;                r.wb = 1'b1; end
      6:  begin r.alu = a | b;                r.wb = 1'b1; end
      7:  begin r.alu = ~(a | b);             r.wb = 1'b1; end
      8:  begin r.alu = a ^ b;                r.wb = 1'b1; end
      9, 10: begin r.alu = a * (32'd1 << sa); r.wb = 1'b1; end
      11: begin r.alu = 32'($signed(a) >>> sa); r.wb = 1'b1; end
      12: begin r.alu = a / (64'd1 << sa);    r.wb = 1'b1; end
      32: begin r.alu = a + imm;              r.wb = 1'b1; end
      33: begin r.alu = a - imm;              r.wb = 1'b1; end
      36: begin r.alu = a + imm;              r.wb = 1'b1; r.mr = 1'b1; end
      37: begin r.alu = a + imm;              r.mw = 1'b1; end
      40: r.tk = (a == 0);
      41: r.tk = (a != b);
      42: r.tk = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  task automatic set_in(input logic [31:0] ins, pc);
    bus.Instruction = ins;
    bus.PC_in       = pc;
    bus.WB_EN_in    = 1'b0;
    bus.WB_Dest_in  = 5'd0;
    bus.WB_Value_in = 32'h0;
  endtask

  task automatic wb(input logic [4:0] idx, input logic [31:0] val);
    set_in(32'h0, 32'h0);
    bus.WB_EN_in    = 1'b1;
    bus.WB_Dest_in  = idx;
    bus.WB_Value_in = val;
    step();
    bus.WB_EN_in = 1'b0;
    if (idx != 5'd0) m_rf[idx] = val;
  endtask

  // One instruction followed by a NOP; check EXE decision then EXE/MEM.
  task automatic apply(input string tag, input vec_t v);
    set_in(v.ins, v.pc);
    step();
    chk({tag, ".taken"}, {31'd0, bus.Branch_taken}, {31'd0, v.tk});
    if (v.tk) chk({tag, ".baddr"}, bus.BranchAddr, v.ba);
    set_in(32'h0, 32'h0);
    step();
    chk({tag, ".wb"}, {31'd0, bus.WB_EN},    {31'd0, v.wb});
    chk({tag, ".mr"}, {31'd0, bus.MEM_R_EN}, {31'd0, v.mr});
    chk({tag, ".mw"}, {31'd0, bus.MEM_W_EN}, {31'd0, v.mw});
    chk({tag, ".pc"}, bus.PC, v.pc);
    if (v.wb || v.mr || v.mw) begin
      chk({tag, ".alu"},  bus.ALU_result, v.alu);
      chk({tag, ".dest"}, {27'd0, bus.Dest}, {27'd0, v.dest});
    end
    if (v.mw) chk({tag, ".st"}, bus.ST_val, v.st);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pc"},    bus.PC, 32'h0);
    chk({tag, ".alu"},   bus.ALU_result, 32'h0);
    chk({tag, ".st"},    bus.ST_val, 32'h0);
    chk({tag, ".dest"},  {27'd0, bus.Dest}, 32'h0);
    chk({tag, ".en"},    {29'd0, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN}, 32'h0);
    chk({tag, ".taken"}, {31'd0, bus.Branch_taken}, 32'h0);
  endtask

  initial begin : main
    int ops [20] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42, 2, 50};
    vec_t v;

    for (int i = 0; i < 32; i++) m_rf[i] = (i == 0) ? 32'h0 : c_RST;
    set_in(32'h0, 32'h0);
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    // Operand registers for the directed table.
    wb(5'd1, 32'd7);
    wb(5'd2, 32'd5);
    wb(5'd7, 32'h8000_0000);
    wb(5'd8, 32'd4);
    wb(5'd9, 32'hFFFF_FFFF);
    wb(5'd10, 32'd1);
    wb(5'd11, 32'h100);

    tbl.push_back(V(mkr(1, 3, 1, 2),        32'h10, 32'd12,        0, 3, 1, 0, 0, 0, 0));
    tbl.push_back(V(mki(33, 4, 0, 16'h1),   32'h14, 32'hFFFF_FFFF, 0, 4, 1, 0, 0, 0, 0));
    tbl.push_back(V(mkr(11, 5, 7, 8),       32'h18, 32'hF800_0000, 0, 5, 1, 0, 0, 0, 0));
    tbl.push_back(V(mkr(1, 5, 9, 10),       32'h1C, 32'h0,         0, 5, 1, 0, 0, 0, 0));
    tbl.push_back(V(mki(36, 6, 11, 16'h8),  32'h24, 32'h108,       0, 6, 1, 1, 0, 0, 0));
    tbl.push_back(V(mki(37, 2, 11, 16'h4),  32'h28, 32'h104,       5, 2, 0, 0, 1, 0, 0));
    tbl.push_back(V(mki(40, 0, 0, 16'h3),   32'h20, 0,             0, 0, 0, 0, 0, 1, 32'h2C));
    tbl.push_back(V(mki(41, 2, 1, 16'hFFFF),32'h40, 0,             0, 0, 0, 0, 0, 1, 32'h3C));
    tbl.push_back(V(mki(41, 1, 1, 16'h5),   32'h40, 0,             0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(mki(42, 0, 0, 16'h10),  32'h100, 0,            0, 0, 0, 0, 0, 1, 32'h140));
    tbl.push_back(V(mki(63, 3, 1, 16'h2),   32'h50, 0,             0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(mkr(10, 5, 10, 8),     32'h54, 32'd16,        0, 5, 1, 0, 0, 0, 0));
    tbl.push_back(V(mkr(12, 5, 7, 8),      32'h58, 32'h0800_0000, 0, 5, 1, 0, 0, 0, 0));
    tbl.push_back(V(mkr(7, 5, 0, 0),       32'h5C, 32'hFFFF_FFFF, 0, 5, 1, 0, 0, 0, 0));
    tbl.push_back(V(mkr(8, 5, 1, 2),       32'h60, 32'd2,         0, 5, 1, 0, 0, 0, 0));
    tbl.push_back(V(mkr(3, 5, 2, 1),       32'h64, 32'hFFFF_FFFE, 0, 5, 1, 0, 0, 0, 0));
    tbl.push_back(V(mkr(5, 5, 1, 2),       32'h68, 32'd5,         0, 5, 1, 0, 0, 0, 0));
    tbl.push_back(V(mkr(6, 5, 1, 2),       32'h6C, 32'd7,         0, 5, 1, 0, 0, 0, 0));
    tbl.push_back(V(mkr(9, 5, 10, 8),      32'h70, 32'd16,        0, 5, 1, 0, 0, 0, 0));
    tbl.push_back(V(mki(32, 5, 1, 16'hFFF9),32'h74, 32'h0,        0, 5, 1, 0, 0, 0, 0));

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Writes to R0 are dropped.
    wb(5'd0, 32'd9);
    apply("r0", V(mkr(1, 3, 0, 0), 32'h80, 32'h0, 0, 3, 1, 0, 0, 0, 0));

    // Writeback landing in the same cycle as the read is bypassed.
    set_in(mkr(1, 13, 12, 0), 32'h84);
    bus.WB_EN_in    = 1'b1;
    bus.WB_Dest_in  = 5'd12;
    bus.WB_Value_in = 32'h55;
    step();
    m_rf[12] = 32'h55;
    set_in(32'h0, 32'h0);
    step();
    chk("bypass.alu", bus.ALU_result, 32'h55);

    // Taken branch squashes the following instruction.
    set_in(mki(40, 0, 0, 16'h3), 32'h20);
    step();
    chk("squash.taken", {31'd0, bus.Branch_taken}, 32'd1);
    chk("squash.baddr", bus.BranchAddr, 32'h2C);
    set_in(mkr(1, 3, 1, 2), 32'h24);
    step();
    chk("squash.br_wb", {31'd0, bus.WB_EN}, 32'd0);
    set_in(32'h0, 32'h0);
    step();
    chk("squash.bubble", {29'd0, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN}, 32'h0);

    // Back-to-back dependent pair.
    wb(5'd20, 32'd3);
    wb(5'd21, 32'd4);
    wb(5'd22, 32'd100);
    set_in(mkr(1, 22, 20, 21), 32'h90);
    step();
    set_in(mkr(1, 23, 22, 22), 32'h94);
    step();
    chk("dep.first", bus.ALU_result, 32'd7);
    set_in(32'h0, 32'h0);
    step();
`ifdef ID_EXE_FORWARD_EN
    chk("dep.second", bus.ALU_result, 32'd14);
`else
    chk("dep.second", bus.ALU_result, 32'd200);
`endif
    step();

    // Randomized instructions against the reference model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        wb(5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      end else begin
        logic [31:0] ins;
        ins = $urandom;
        ins[31:26] = 6'(ops[$urandom_range(0, 19)]);
        if ($urandom_range(0, 3) == 0) ins[20:16] = ins[25:21];
        v = model(ins, $urandom & 32'hFFFF_FFFC);
        apply($sformatf("rnd%0d", n), v);
      end
    end

    // Mid-run reset.
    wb(5'd5, 32'hDEAD_BEEF);
    set_in(mkr(1, 3, 5, 0), 32'hA0);
    step();
    set_in(mki(42, 0, 0, 16'h1), 32'hA4);
    step();
    chk("pre_rst.wb", {31'd0, bus.WB_EN}, 32'd1);
    chk("pre_rst.taken", {31'd0, bus.Branch_taken}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    set_in(32'h0, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 1; i < 32; i++) m_rf[i] = c_RST;
    apply("post_rst.r5", V(mkr(1, 6, 5, 0), 32'hB0, c_RST, 0, 6, 1, 0, 0, 0, 0));
    apply("post_rst.r0", V(mkr(1, 6, 0, 0), 32'hB4, 32'h0, 0, 6, 1, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
